// File: rtl/bus_slave_demux_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_demux_pkg
// Shared definitions for the bus slave demultiplexer: the transaction state
// encoding, the default region codes (address[29:26]) and the one-hot region
// hit type produced by the region decoder.
// -----------------------------------------------------------------------------
package bus_slave_demux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_IO = 2'd2,
        RESP    = 2'd3
    } busState_t;

    localparam logic [3:0] ROM_REGION_DEF     = 4'h0;
    localparam logic [3:0] RAM_REGION_DEF     = 4'h1;
    localparam logic [3:0] IO_REGION_DEF      = 4'h4;
    localparam int         TIMEOUT_CYCLES_DEF = 16;

    typedef struct packed {
        logic rom;
        logic ram;
        logic io;
    } regionHit_t;

endpackage

// File: rtl/bus_slave_demux_decoder.sv
// -----------------------------------------------------------------------------
// bus_region_decoder
// Combinational region decode of a word address.
//   region      in  4   address[29:26]
//   writeEnable in  1   1 = write access
//   hit         out 3   one-hot {rom, ram, io}; all zero on error
//   decodeError out 1   unmapped region, or a write aimed at ROM
// -----------------------------------------------------------------------------
module bus_region_decoder
    import bus_slave_demux_pkg::*;
#(
    parameter logic [3:0] ROM_REGION = ROM_REGION_DEF,
    parameter logic [3:0] RAM_REGION = RAM_REGION_DEF,
    parameter logic [3:0] IO_REGION  = IO_REGION_DEF
) (
    input  logic [3:0] region,
    input  logic       writeEnable,
    output regionHit_t hit,
    output logic       decodeError
);

    always_comb begin
        hit         = '0;
        decodeError = 1'b0;
        if (region == ROM_REGION) begin
            // ROM is read-only; a write is answered with an error, not a select
            if (writeEnable) decodeError = 1'b1;
            else             hit.rom     = 1'b1;
        end else if (region == RAM_REGION) begin
            hit.ram = 1'b1;
        end else if (region == IO_REGION) begin
            hit.io = 1'b1;
        end else begin
            decodeError = 1'b1;
        end
    end

endmodule

// File: rtl/bus_slave_demux.sv
// -----------------------------------------------------------------------------
// bus_slave_demux
// Single-outstanding bus slave demultiplexer. Latches a master request, routes
// it to ROM, RAM or MMIO by address[29:26], and returns a one-cycle response.
//
// Master side : clk, rst, req, address, writeEnable, writeData, byteEnable
//               -> ready, readData, error
// Slave side  : slvAddress, slvWriteEnable, slvWriteData, slvByteEnable,
//               selRom, selRam, selIo <- romReadData, ramReadData,
//               ioReadData, ioReady
//
// Optional build macro BUS_SLAVE_TIMEOUT_EN: adds an MMIO wait timeout that
// ends a stalled access with an error after TIMEOUT_CYCLES cycles.
//
// state   | meaning
// IDLE    | waiting for req; latches the request and decodes its region
// ACCESS  | one-cycle ROM/RAM select, read data captured
// WAIT_IO | selIo held until ioReady (or timeout when enabled)
// RESP    | ready strobe with captured readData/error
// -----------------------------------------------------------------------------
module bus_slave_demux
    import bus_slave_demux_pkg::*;
#(
    parameter logic [3:0] ROM_REGION     = ROM_REGION_DEF,
    parameter logic [3:0] RAM_REGION     = RAM_REGION_DEF,
    parameter logic [3:0] IO_REGION      = IO_REGION_DEF,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [29:0] address,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    input  logic [3:0]  byteEnable,
    output logic        ready,
    output logic [31:0] readData,
    output logic        error,
    output logic [29:0] slvAddress,
    output logic        slvWriteEnable,
    output logic [31:0] slvWriteData,
    output logic [3:0]  slvByteEnable,
    output logic        selRom,
    output logic        selRam,
    output logic        selIo,
    input  logic [31:0] romReadData,
    input  logic [31:0] ramReadData,
    input  logic [31:0] ioReadData,
    input  logic        ioReady
);

    busState_t   state, stateNext;
    regionHit_t  hit;
    logic        decodeError;
    logic        accessRom;
    logic        acceptReq;
    logic        loadResp;
    logic [31:0] respData, respDataNext;
    logic        respError, respErrorNext;
    logic        timeoutHit;

    bus_region_decoder #(
        .ROM_REGION (ROM_REGION),
        .RAM_REGION (RAM_REGION),
        .IO_REGION  (IO_REGION)
    ) uDecoder (
        .region      (address[29:26]),
        .writeEnable (writeEnable),
        .hit         (hit),
        .decodeError (decodeError)
    );

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam int                 IO_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IO_CNT_W-1:0] TIMEOUT_LAST = IO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [IO_CNT_W-1:0] ioWaitCount;

    // Counts WAIT_IO cycles that ended without ioReady. The limit is reached
    // on the edge leaving the last allowed cycle, so selIo stays high for
    // exactly TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ioWaitCount <= '0;
        end else if (acceptReq && hit.io) begin
            ioWaitCount <= '0;
        end else if (state == WAIT_IO && !ioReady) begin
            ioWaitCount <= ioWaitCount + 1'b1;
        end
    end

    assign timeoutHit = (state == WAIT_IO) && (ioWaitCount == TIMEOUT_LAST);
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
    assign timeoutHit       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        acceptReq     = 1'b0;
        loadResp      = 1'b0;
        respDataNext  = '0;
        respErrorNext = 1'b0;
        ready         = 1'b0;
        selRom        = 1'b0;
        selRam        = 1'b0;
        selIo         = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    acceptReq = 1'b1;
                    if (decodeError) begin
                        stateNext     = RESP;
                        loadResp      = 1'b1;
                        respErrorNext = 1'b1;
                    end else if (hit.io) begin
                        stateNext = WAIT_IO;
                    end else if (hit.rom || hit.ram) begin
                        stateNext = ACCESS;
                    end
                end
            end
            ACCESS: begin
                selRom    = accessRom;
                selRam    = !accessRom;
                stateNext = RESP;
                loadResp  = 1'b1;
                if (!slvWriteEnable)
                    respDataNext = accessRom ? romReadData : ramReadData;
            end
            WAIT_IO: begin
                selIo = 1'b1;
                // ioReady takes priority over a timeout landing in the same cycle
                if (ioReady) begin
                    stateNext = RESP;
                    loadResp  = 1'b1;
                    if (!slvWriteEnable) respDataNext = ioReadData;
                end else if (timeoutHit) begin
                    stateNext     = RESP;
                    loadResp      = 1'b1;
                    respErrorNext = 1'b1;
                end
            end
            RESP: begin
                ready     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slvAddress     <= '0;
            slvWriteEnable <= 1'b0;
            slvWriteData   <= '0;
            slvByteEnable  <= '0;
            accessRom      <= 1'b0;
            respData       <= '0;
            respError      <= 1'b0;
        end else begin
            if (acceptReq) begin
                slvAddress     <= address;
                slvWriteEnable <= writeEnable;
                slvWriteData   <= writeData;
                slvByteEnable  <= byteEnable;
                accessRom      <= hit.rom;
            end
            if (loadResp) begin
                respData  <= respDataNext;
                respError <= respErrorNext;
            end
        end
    end

    // Response fields are gated so they read as zero outside the ready strobe.
    assign readData = ready ? respData : '0;
    assign error    = ready & respError;

endmodule

// File: tb/tb_bus_slave_demux.sv
module tb_bus_slave_demux;

    localparam logic [31:0] ROM_DATA = 32'hC0DE_0001;
    localparam logic [31:0] RAM_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] IO_DATA  = 32'h1234_5678;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [29:0] address;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [3:0]  byteEnable;
    logic        ready;
    logic [31:0] readData;
    logic        error;
    logic [29:0] slvAddress;
    logic        slvWriteEnable;
    logic [31:0] slvWriteData;
    logic [3:0]  slvByteEnable;
    logic        selRom, selRam, selIo;
    logic [31:0] romReadData, ramReadData, ioReadData;
    logic        ioReady;

    int vectors     = 0;
    int miscompares = 0;
    logic [32:0] sbQ[$];

    always #5 clk = ~clk;

    bus_slave_demux dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .address        (address),
        .writeEnable    (writeEnable),
        .writeData      (writeData),
        .byteEnable     (byteEnable),
        .ready          (ready),
        .readData       (readData),
        .error          (error),
        .slvAddress     (slvAddress),
        .slvWriteEnable (slvWriteEnable),
        .slvWriteData   (slvWriteData),
        .slvByteEnable  (slvByteEnable),
        .selRom         (selRom),
        .selRam         (selRam),
        .selIo          (selIo),
        .romReadData    (romReadData),
        .ramReadData    (ramReadData),
        .ioReadData     (ioReadData),
        .ioReady        (ioReady)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, ":ready"},   {31'b0, ready}, 32'd0);
        check({tag, ":error"},   {31'b0, error}, 32'd0);
        check({tag, ":rdata"},   readData, 32'd0);
        check({tag, ":sel"},     {29'b0, selRom, selRam, selIo}, 32'd0);
        check({tag, ":slvAddr"}, {2'b0, slvAddress}, 32'd0);
        check({tag, ":slvWe"},   {31'b0, slvWriteEnable}, 32'd0);
        check({tag, ":slvWd"},   slvWriteData, 32'd0);
        check({tag, ":slvBe"},   {28'b0, slvByteEnable}, 32'd0);
    endtask

    // ioDelay: cycles of selIo before ioReady is raised (-1 = never).
    // busy: 1 when the DUT is still in RESP as this request is driven.
    task automatic doTxn(input string tag, input logic [29:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int ioDelay, input int busy, input bit hold);
        logic [3:0]  region;
        int          kind;  // 0 rom, 1 ram, 2 io, 3 error
        logic        expErr;
        logic [31:0] expData;
        int          expIoSel, expLat;
        int          romSeen, ramSeen, ioSeen, gotK;
        logic [32:0] exp;

        region = a[29:26];
        if (region == 4'h0)      kind = we ? 3 : 0;
        else if (region == 4'h1) kind = 1;
        else if (region == 4'h4) kind = 2;
        else                     kind = 3;

        expErr   = (kind == 3);
        expIoSel = 0;
        case (kind)
            0: expData = ROM_DATA;
            1: expData = RAM_DATA;
            2: expData = IO_DATA;
            default: expData = 32'd0;
        endcase
        if (kind == 2) begin
`ifdef BUS_SLAVE_TIMEOUT_EN
            if (ioDelay < 0 || ioDelay + 1 > TMO) begin
                expIoSel = TMO;
                expErr   = 1'b1;
                expData  = 32'd0;
            end else begin
                expIoSel = ioDelay + 1;
            end
`else
            expIoSel = ioDelay + 1;
`endif
        end
        if (we) expData = 32'd0;
        if (kind == 3)      expLat = 1 + busy;
        else if (kind == 2) expLat = expIoSel + 1 + busy;
        else                expLat = 2 + busy;

        address     = a;
        writeEnable = we;
        writeData   = wd;
        byteEnable  = be;
        req         = 1'b1;
        sbQ.push_back({expErr, expData});

        romSeen = 0; ramSeen = 0; ioSeen = 0; gotK = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            ioReady = 1'b0;
            if (k == 1 + busy) begin
                check({tag, ":slvAddr"}, {2'b0, slvAddress}, {2'b0, a});
                check({tag, ":slvWe"},   {31'b0, slvWriteEnable}, {31'b0, we});
                check({tag, ":slvWd"},   slvWriteData, wd);
                check({tag, ":slvBe"},   {28'b0, slvByteEnable}, {28'b0, be});
                // inputs now scrambled; the DUT must keep its latched copy
                address     = 30'($urandom);
                writeData   = $urandom;
                writeEnable = ~we;
                byteEnable  = ~be;
                req         = hold;
            end
            if (selRom) romSeen++;
            if (selRam) ramSeen++;
            if (selIo) begin
                ioSeen++;
                if (ioDelay >= 0 && ioSeen == ioDelay + 1) ioReady = 1'b1;
            end
            if (ready) begin
                gotK = k;
                break;
            end
        end
        ioReady = 1'b0;

        check({tag, ":latency"}, gotK, expLat);
        check({tag, ":selRomCnt"}, romSeen, (kind == 0) ? 1 : 0);
        check({tag, ":selRamCnt"}, ramSeen, (kind == 1) ? 1 : 0);
        check({tag, ":selIoCnt"},  ioSeen, expIoSel);
        if (gotK != 0) begin
            exp = sbQ.pop_front();
            check({tag, ":rdata"}, readData, exp[31:0]);
            check({tag, ":error"}, {31'b0, error}, {31'b0, exp[32]});
        end
    endtask

    initial begin
        bit sawReady;

        rst         = 1'b1;
        req         = 1'b0;
        address     = '0;
        writeEnable = 1'b0;
        writeData   = '0;
        byteEnable  = '0;
        romReadData = ROM_DATA;
        ramReadData = RAM_DATA;
        ioReadData  = IO_DATA;
        ioReady     = 1'b0;

        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        doTxn("ramRead",  30'h0400_0010, 1'b0, 32'h0,         4'hF, 0, 0, 1'b0);
        @(negedge clk);
        doTxn("romWrite", 30'h0000_0004, 1'b1, 32'hAAAA_5555, 4'h3, 0, 0, 1'b0);
        @(negedge clk);
        doTxn("ioRead",   30'h1000_0000, 1'b0, 32'h0,         4'hF, 5, 0, 1'b0);
        @(negedge clk);
        doTxn("romRead",  30'h0000_0100, 1'b0, 32'h0,         4'hF, 0, 0, 1'b0);
        @(negedge clk);
        doTxn("ramWrite", 30'h07FF_FFFC, 1'b1, 32'h0BAD_F00D, 4'h6, 0, 0, 1'b0);
        @(negedge clk);
        doTxn("ioWrite",  30'h13FF_0008, 1'b1, 32'h5A5A_A5A5, 4'h1, 2, 0, 1'b0);
        @(negedge clk);
        doTxn("unmapped", 30'h3C00_0000, 1'b0, 32'h0,         4'hF, 0, 0, 1'b0);
        @(negedge clk);
`ifdef BUS_SLAVE_TIMEOUT_EN
        doTxn("ioTimeout", 30'h1000_0020, 1'b0, 32'h0, 4'hF, -1,      0, 1'b0);
        @(negedge clk);
        doTxn("ioEdge",    30'h1000_0024, 1'b0, 32'h0, 4'hF, TMO - 1, 0, 1'b0);
        @(negedge clk);
`else
        doTxn("ioLong",    30'h1000_0020, 1'b0, 32'h0, 4'hF, 20,      0, 1'b0);
        @(negedge clk);
`endif

        // back-to-back with req held high across transactions
        doTxn("b2bRam", 30'h0400_0040, 1'b0, 32'h0, 4'hF, 0, 0, 1'b1);
        doTxn("b2bRom", 30'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 1, 1'b1);
        doTxn("b2bErr", 30'h2000_0000, 1'b1, 32'h1,  4'hF, 0, 1, 1'b1);
        doTxn("b2bIo",  30'h1000_0040, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0);
        @(negedge clk);

        // reset in the middle of an MMIO wait
        address     = 30'h1000_0080;
        writeEnable = 1'b0;
        writeData   = 32'h0;
        byteEnable  = 4'hF;
        req         = 1'b1;
        repeat (3) @(negedge clk);
        check("rstMid:selIoBefore", {31'b0, selIo}, 32'd1);
        req = 1'b0;
        rst = 1'b1;
        #1;
        checkIdleOutputs("rstMid");
        @(negedge clk);
        rst = 1'b0;
        sawReady = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready || selIo) sawReady = 1'b1;
        end
        check("rstMid:noResponse", {31'b0, sawReady}, 32'd0);
        check("scoreboardEmpty", sbQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
